// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding imem reads into a 2-entry {insn, pc} FIFO feeding decode.
// Redirects flush the FIFO and squash any response still in flight.
module fetch_ctrl #(
   parameter int unsigned       AWIDTH   = 32,
   parameter int unsigned       DWIDTH   = 32,
   parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [AWIDTH-1:0] imem_req_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   output logic              dec_valid_o,
   input  logic              dec_ready_i,
   output logic [DWIDTH-1:0] dec_insn_o,
   output logic [AWIDTH-1:0] dec_pc_o,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i
);

   localparam int unsigned DEPTH = 2;

   logic [AWIDTH-1:0] r_pc;
   logic [AWIDTH-1:0] r_req_pc;
   logic              r_outstanding;
   logic              r_squash;
   logic [DWIDTH-1:0] r_fifo_insn [DEPTH];
   logic [AWIDTH-1:0] r_fifo_pc   [DEPTH];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;

   logic w_req_valid;
   logic w_req_fire;
   logic w_push;
   logic w_pop;
   logic w_dec_valid;

   // count<=1 gate reserves a FIFO slot for the single in-flight response
   assign w_req_valid = !rst && !r_outstanding && (r_count <= 2'd1) && !redirect_i;
   assign w_req_fire  = w_req_valid && imem_req_ready_i;
   assign w_push      = imem_rsp_valid_i && !r_squash && !redirect_i;
   assign w_dec_valid = (r_count != 2'd0);
   assign w_pop       = w_dec_valid && dec_ready_i && !redirect_i;

   assign imem_req_valid_o = w_req_valid;
   assign imem_req_addr_o  = r_pc;
   assign dec_valid_o      = w_dec_valid;
   assign dec_insn_o       = w_dec_valid ? r_fifo_insn[r_rd_ptr] : '0;
   assign dec_pc_o         = w_dec_valid ? r_fifo_pc[r_rd_ptr]   : '0;

   // Fetch PC, in-flight tracking and squash
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_outstanding <= 1'b0;
         r_squash      <= 1'b0;
      end else begin
         if (redirect_i) begin
            r_pc <= redirect_pc_i;
         end else if (w_req_fire) begin
            r_pc <= r_pc + AWIDTH'(4);
         end

         if (w_req_fire) begin
            r_outstanding <= 1'b1;
            r_req_pc      <= r_pc;
         end else if (imem_rsp_valid_i) begin
            r_outstanding <= 1'b0;
         end

         if (imem_rsp_valid_i) begin
            r_squash <= 1'b0;
         end else if (redirect_i && r_outstanding) begin
            r_squash <= 1'b1;
         end
      end
   end

   // Instruction FIFO; a redirect flushes it and overrides any push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (redirect_i) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; outputs are gated by count
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_fifo_insn[r_wr_ptr] <= imem_rsp_data_i;
         r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle-stepped stimulus with a small latency-programmable imem model.
module tb_fetch_ctrl;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [31:0] dec_insn_o;
   logic [31:0] dec_pc_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   fetch_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .dec_valid_o      (dec_valid_o),
      .dec_ready_i      (dec_ready_i),
      .dec_insn_o       (dec_insn_o),
      .dec_pc_o         (dec_pc_o),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Observations from the most recent cycle
   logic        c_rv, c_acc, c_dv, c_pop;
   logic [31:0] c_addr, c_dpc, c_dinsn;

   // imem model state
   int          m_lat  = 1;
   logic        m_pend = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] m_addr = '0;

   logic [31:0] acc_q[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_insn[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Run one cycle: sample settled outputs, clock, then drive the next imem response
   task automatic step();
      #2;
      c_rv    = imem_req_valid_o;
      c_addr  = imem_req_addr_o;
      c_acc   = imem_req_valid_o & imem_req_ready_i;
      c_dv    = dec_valid_o;
      c_dpc   = dec_pc_o;
      c_dinsn = dec_insn_o;
      c_pop   = dec_valid_o & dec_ready_i & !redirect_i;
      if (c_acc) acc_q.push_back(c_addr);
      if (c_pop) begin
         pop_pc.push_back(c_dpc);
         pop_insn.push_back(c_dinsn);
      end
      @(posedge clk);
      #1;
      imem_rsp_valid_i = 1'b0;
      if (rst) begin
         m_pend = 1'b0;
      end else begin
         if (m_pend) begin
            if (m_cnt == 1) begin
               imem_rsp_valid_i = 1'b1;
               imem_rsp_data_i  = m_addr ^ K;
               m_pend = 1'b0;
            end else begin
               m_cnt--;
            end
         end
         if (c_acc) begin
            if (m_lat == 1) begin
               imem_rsp_valid_i = 1'b1;
               imem_rsp_data_i  = c_addr ^ K;
            end else begin
               m_pend = 1'b1;
               m_addr = c_addr;
               m_cnt  = m_lat - 1;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      acc_q.delete();
      pop_pc.delete();
      pop_insn.delete();
   endtask

   initial begin
      rst = 1'b1;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      dec_ready_i      = 1'b1;
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      @(posedge clk);
      #1;

      // Reset outputs and basic streaming
      m_lat = 1;
      rst = 1'b1;
      step();
      step();
      chk("rst_req_valid", 32'(c_rv), 32'd0);
      chk("rst_dec_valid", 32'(c_dv), 32'd0);
      chk("rst_dec_insn", c_dinsn, 32'd0);
      chk("rst_dec_pc", c_dpc, 32'd0);
      rst = 1'b0;
      acc_q.delete(); pop_pc.delete(); pop_insn.delete();
      step();
      chk("s1_acc0", 32'(c_acc), 32'd1);
      chk("s1_addr0", c_addr, 32'h0100_0000);
      step();
      chk("s1_dv_early", 32'(c_dv), 32'd0);
      step();
      chk("s1_dv_lat2", 32'(c_dv), 32'd1);
      chk("s1_first_pc", c_dpc, 32'h0100_0000);
      chk("s1_first_insn", c_dinsn, 32'hA4A5_0000);
      for (int i = 0; i < 5; i++) step();
      chk("s1_req1", acc_q[1], 32'h0100_0004);
      chk("s1_req2", acc_q[2], 32'h0100_0008);
      chk("s1_pop1_pc", pop_pc[1], 32'h0100_0004);
      chk("s1_pop1_insn", pop_insn[1], 32'hA4A5_0004);
      chk("s1_pop2_insn", pop_insn[2], 32'hA4A5_0008);

      // Decode backpressure
      dec_ready_i = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) step();
      chk("s2_stuck_rv", 32'(c_rv), 32'd0);
      chk("s2_nreq", 32'(acc_q.size()), 32'd2);
      chk("s2_head_pc", c_dpc, 32'h0100_0000);
      dec_ready_i = 1'b1;
      step();
      chk("s2_pop", 32'(c_pop), 32'd1);
      dec_ready_i = 1'b0;
      step();
      chk("s2_next_acc", 32'(c_acc), 32'd1);
      chk("s2_next_addr", c_addr, 32'h0100_0008);
      chk("s2_new_head", c_dpc, 32'h0100_0004);
      step();
      step();
      dec_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("s2_order0", pop_pc[0], 32'h0100_0000);
      chk("s2_order1", pop_pc[1], 32'h0100_0004);
      chk("s2_order2", pop_pc[2], 32'h0100_0008);
      chk("s2_insn2", pop_insn[2], 32'hA4A5_0008);

      // Redirect while a slow response is in flight
      dec_ready_i = 1'b1;
      m_lat = 1;
      do_reset();
      step();
      m_lat = 3;
      step();
      step();
      chk("s3_acc04", c_addr, 32'h0100_0004);
      step();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      step();
      chk("s3_rv_redir", 32'(c_rv), 32'd0);
      redirect_i = 1'b0;
      m_lat = 1;
      step();
      chk("s3_rv_squash", 32'(c_rv), 32'd0);
      step();
      chk("s3_acc200", 32'(c_acc), 32'd1);
      chk("s3_addr200", c_addr, 32'h0000_0200);
      chk("s3_dropped_g", 32'(c_dv), 32'd0);
      step();
      chk("s3_dropped_h", 32'(c_dv), 32'd0);
      step();
      chk("s3_dv", 32'(c_dv), 32'd1);
      chk("s3_pc", c_dpc, 32'h0000_0200);
      chk("s3_insn", c_dinsn, 32'hA5A5_0200);

      // Redirect coincident with response and pop, FIFO holding one entry
      dec_ready_i = 1'b0;
      m_lat = 1;
      do_reset();
      step();
      step();
      step();
      chk("s4_acc04", c_addr, 32'h0100_0004);
      dec_ready_i = 1'b1;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0300;
      step();
      chk("s4_rv_redir", 32'(c_rv), 32'd0);
      chk("s4_dv_redir", 32'(c_dv), 32'd1);
      redirect_i = 1'b0;
      step();
      chk("s4_flushed", 32'(c_dv), 32'd0);
      chk("s4_acc_r1", 32'(c_acc), 32'd1);
      chk("s4_addr_r1", c_addr, 32'h0000_0300);
      step();
      chk("s4_dropped", 32'(c_dv), 32'd0);
      step();
      chk("s4_dv", 32'(c_dv), 32'd1);
      chk("s4_pc", c_dpc, 32'h0000_0300);

      // Memory stall, then reset mid-stall
      dec_ready_i = 1'b1;
      imem_req_ready_i = 1'b1;
      do_reset();
      step();
      step();
      imem_req_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("s5_stall_rv", 32'(c_rv), 32'd1);
         chk("s5_stall_addr", c_addr, 32'h0100_0004);
      end
      rst = 1'b1;
      step();
      chk("s5_rst_rv", 32'(c_rv), 32'd0);
      chk("s5_rst_dv", 32'(c_dv), 32'd0);
      rst = 1'b0;
      imem_req_ready_i = 1'b1;
      step();
      chk("s5_post_acc", 32'(c_acc), 32'd1);
      chk("s5_post_addr", c_addr, 32'h0100_0000);
      chk("s5_post_dv", 32'(c_dv), 32'd0);

      // PC wrap
      do_reset();
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      step();
      chk("s6_rv_redir", 32'(c_rv), 32'd0);
      redirect_i = 1'b0;
      step();
      chk("s6_addr_top", c_addr, 32'hFFFF_FFFC);
      step();
      step();
      chk("s6_addr_wrap", c_addr, 32'h0000_0000);
      chk("s6_dpc_top", c_dpc, 32'hFFFF_FFFC);
      chk("s6_insn_top", c_dinsn, 32'h5A5A_FFFC);
      step();
      step();
      chk("s6_dpc_wrap", c_dpc, 32'h0000_0000);
      chk("s6_insn_wrap", c_dinsn, 32'hA5A5_0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that feeds the decode stage. It holds the fetch PC and issues single-outstanding instruction-memory reads over a valid/ready request channel. Responses are buffered in a 2-entry instruction FIFO that drives decode (insn plus PC) through a valid/ready handshake. A redirect from execute (branch, jump or JALR target) flushes in-flight work and restarts fetch at the new PC.

Parameters:
AWIDTH, 32, address/PC width
DWIDTH, 32, instruction width
RESET_PC, 32'h0100_0000, fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  AWIDTH  fetch address (current PC)
imem_rsp_valid_i  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance
imem_rsp_data_i  in  DWIDTH  instruction word
dec_valid_o  out  1  FIFO head valid to decode
dec_ready_i  in  1  decode consumes head
dec_insn_o  out  DWIDTH  head instruction (insn_i of decode)
dec_pc_o  out  AWIDTH  head PC (pc_i of decode)
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  AWIDTH  new fetch PC, 4-byte aligned

Behaviour:
- State: pc, outstanding flag, squash flag, req_pc (PC of in-flight request), 2-entry FIFO {insn, pc} with rd/wr pointers and count (0..2).
- Reset (synchronous, wins over everything): pc=RESET_PC, outstanding=0, squash=0, count=0, pointers=0.
  - Outputs during and after reset: imem_req_valid_o=0 while rst=1; dec_valid_o=0; dec_insn_o/dec_pc_o=0.
  - A response arriving after reset from a pre-reset request is the memory's responsibility; the memory is reset simultaneously.
- Request issue: imem_req_valid_o = !rst && !outstanding && (count<=1) && !redirect_i. imem_req_addr_o = pc.
  - Request accepted when valid && ready. On acceptance: outstanding<=1, req_pc<=pc, pc<=pc+4 (mod 2^AWIDTH; wraps at 0xFFFF_FFFC to 0).
  - Valid is held stable with constant addr until ready, unless a redirect arrives; requests are never withdrawn otherwise.
- Response: on imem_rsp_valid_i, outstanding<=0.
  - Write {data, req_pc} into the FIFO unless squash=1 or redirect_i=1 in the same cycle; the response is dropped in those cases.
  - Squash clears on any response.
- Next request may issue no earlier than the cycle after the response (outstanding is registered). The count<=1 gate guarantees the FIFO never overflows.
- Decode side: dec_valid_o = (count!=0). Head pops when dec_valid_o && dec_ready_i. A simultaneous push and pop leaves count unchanged.
- Latency: request accepted in cycle N, response in cycle N+k, dec_valid_o high in cycle N+k+1 (FIFO registered; no bypass).
- Redirect (redirect_i=1 in cycle R):
  - pc<=redirect_pc_i.
  - FIFO flushed: count<=0, pointers reset. A pop in cycle R is ignored, and dec_valid_o is 0 from R+1.
  - If outstanding && !imem_rsp_valid_i: squash<=1.
  - No request is issued in cycle R. The first request to redirect_pc_i goes out at R+1 if no request is outstanding, otherwise the cycle after the squashed response.
  - A redirect while squash is already set just updates pc; squash stays set.
- Misaligned redirect_pc_i is unsupported; the PC is used as given.

Test Plan:
- Reset, then imem ready=1, responds 1 cycle after acceptance with data=addr^32'hA5A5_0000, dec_ready=1.
  - Required: requests to 0x0100_0000, 0x0100_0004, 0x0100_0008.
  - Required: decode sees (0x0100_0000, 0xA4A5_0000) first, with dec_valid 2 cycles after the first acceptance.
  - Required: insn/pc pairs stay matched.
- Backpressure: dec_ready=0 from reset.
  - Required: exactly 2 responses buffered and imem_req_valid_o stuck at 0.
  - Required: after dec_ready=1 for one cycle, the head 0x0100_0000 pops and the next request to 0x0100_0008 issues.
  - Required: no data loss or reordering.
- Redirect during wait: request 0x0100_0004 accepted, redirect_pc=0x0000_0200 pulsed 1 cycle before its 3-cycle-late response.
  - Required: that response is dropped, the next request addr is 0x0000_0200, and decode's next PC is 0x0000_0200.
- Redirect coincident with imem_rsp_valid_i and with dec pop, FIFO holding 1 entry.
  - Required: response dropped, FIFO empty next cycle, squash not set, request to redirect_pc at R+1.
- Memory stall: ready=0 for 5 cycles.
  - Required: valid stays 1 with addr constant.
  - Required: rst asserted mid-stall gives valid=0 during rst, then a request to 0x0100_0000 with dec_valid=0.
- Wrap: redirect to 0xFFFF_FFFC.
  - Required: fetches 0xFFFF_FFFC then 0x0000_0000, with decode PCs matching.
